control_unit: RTL and testbench

- Hardwired Mini SRC control sequencer: the initiator side of the datapath control interface.
- Generates every bus-enable, register-load, memory and ALU-select strobe the datapath consumes, from the IR contents and the CON flag.
- Replaces hand-driven per-step stimulus: runs fetch/decode/execute continuously from reset until halt.

---
 rtl/minisrc_pkg.sv | 72 +++++++
 rtl/control_step_decoder.sv | 87 ++++++++
 rtl/control_unit.sv | 125 ++++++++++++
 tb/tb_control_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// Mini SRC control package: opcode and ALU-select encodings, sequencer state
// encoding, the control-word struct driven by the step decoder, and helpers
// for each instruction's final execute step and its ALU select.
package minisrc_pkg;

  // Opcodes, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;  // first R-type
  localparam logic [4:0] OP_SHL  = 5'b01011;  // last R-type
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU selects that differ from the opcode value
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH0, ST_FETCH1, ST_FETCH2,
    ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef struct packed {
    logic       pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in;
    logic       outport_in, inc_pc;
    logic       pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out;
    logic       inport_out, c_out;
    logic       read, write;
    logic       gra, grb, grc, rin, rout, baout;
    logic       con_en, r15_in;
    logic [4:0] alu;
  } ctrl_t;

  // Final execute step; the step after it is the instruction boundary.
  function automatic state_t last_step(input logic [4:0] op);
    case (op) inside
      OP_LD, OP_ST:                return ST_T7;
      OP_LDI, [OP_ADD:OP_ORI]:     return ST_T5;
      OP_DIV, OP_MUL, OP_BR:       return ST_T6;
      OP_NEG, OP_NOT, OP_JAL:      return ST_T4;
      default:                     return ST_T3;
    endcase
  endfunction

  // Address arithmetic (ld/ldi/st/br) and addi add; andi/ori map onto the
  // register forms; everything else passes its opcode straight through.
  function automatic logic [4:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_BR, OP_ADDI: return ALU_ADD;
      OP_ANDI:                              return ALU_AND;
      OP_ORI:                               return ALU_OR;
      default:                              return op;
    endcase
  endfunction

endpackage

// File: rtl/control_step_decoder.sv
// Combinational step decoder: (state, opcode, CON) -> control word.
// Ports:
//   i_state  current sequencer state
//   i_opcode IR[31:27]
//   i_con    CON FF result (only gates PC_in in br T6)
//   o_ctrl   full control word; all zero in RESET and HALT
module control_step_decoder
  import minisrc_pkg::*;
(
  input  state_t     i_state,
  input  logic [4:0] i_opcode,
  input  logic       i_con,
  output ctrl_t      o_ctrl
);

  ctrl_t c;
  logic  w_alu_en;

  always_comb begin
    c        = '0;
    w_alu_en = 1'b0;
    case (i_state)
      ST_FETCH0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
      ST_FETCH1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      ST_FETCH2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      ST_T3: begin
        case (i_opcode) inside
          OP_LD, OP_LDI, OP_ST: begin c.grb = 1'b1; c.baout = 1'b1; c.y_in = 1'b1; end
          [OP_ADD:OP_ORI]:      begin c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          OP_DIV, OP_MUL:       begin c.gra = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          OP_NEG, OP_NOT: begin c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; w_alu_en = 1'b1; end
          OP_BR:   begin c.gra = 1'b1; c.rout = 1'b1; c.con_en = 1'b1; end
          OP_JR:   begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
          OP_JAL:  begin c.pc_out = 1'b1; c.r15_in = 1'b1; end
          OP_IN:   begin c.inport_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_OUT:  begin c.gra = 1'b1; c.rout = 1'b1; c.outport_in = 1'b1; end
          OP_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (i_opcode) inside
          OP_LD, OP_LDI, OP_ST, [OP_ADDI:OP_ORI]:
            begin c.c_out = 1'b1; c.z_in = 1'b1; w_alu_en = 1'b1; end
          [OP_ADD:OP_SHL]: begin c.grc = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; w_alu_en = 1'b1; end
          OP_DIV, OP_MUL:  begin c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; w_alu_en = 1'b1; end
          OP_NEG, OP_NOT:  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_BR:           begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          OP_JAL:          begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (i_opcode) inside
          OP_LDI, [OP_ADD:OP_ORI]: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_LD, OP_ST:    begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
          OP_DIV, OP_MUL:  begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
          OP_BR:           begin c.c_out = 1'b1; c.z_in = 1'b1; w_alu_en = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (i_opcode)
          OP_LD:           begin c.read = 1'b1; c.mdr_in = 1'b1; end
          OP_ST:           begin c.gra = 1'b1; c.rout = 1'b1; c.mdr_in = 1'b1; end
          OP_DIV, OP_MUL:  begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
          // Branch target is always computed; only the load is conditional.
          OP_BR:           begin c.zlow_out = 1'b1; c.pc_in = i_con; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (i_opcode)
          OP_LD:   begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_ST:   c.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    if (w_alu_en) c.alu = alu_sel(i_opcode);
  end

  assign o_ctrl = c;

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer. Owns the state register, the
// post-reset idle counter and halt handling; strobes come from the step
// decoder (Moore on state + opcode, with CON gating br's PC load).
// Ports:
//   clk, clr (async active-high)   IR, CON_in, Stop
//   register-load / bus-drive / memory / select strobes to the datapath
//   alu_instruction_bits           ALU op during ALU steps, else 0
//   Run                            1 outside RESET and HALT
module control_unit
  import minisrc_pkg::*;
#(
  parameter int RESET_CYCLES    = 1,
  parameter int HALT_ON_UNKNOWN = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_in,
  input  logic        Stop,
  output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
  output logic        OutPort_in, IncPC,
  output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
  output logic        InPort_out, C_out,
  output logic        Read, Write,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        CON_en, R15_in,
  output logic [4:0]  alu_instruction_bits,
  output logic        Run
);

  localparam int            CW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [4:0]    w_op;
  logic          w_halt_op;
  state_t        w_boundary;
  ctrl_t         w_ctrl;
  logic          w_unused_ir;

  assign w_op        = IR[31:27];
  assign w_unused_ir = ^IR[26:0];

  assign w_halt_op  = (w_op == OP_HALT) || ((w_op > OP_HALT) && (HALT_ON_UNKNOWN != 0));
  // Stop is only honoured where a new fetch would begin.
  assign w_boundary = Stop ? ST_HALT : ST_FETCH0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_RESET: begin
        if (r_cnt == CNT_LAST) w_next = w_boundary;
        else                   w_cnt_next = r_cnt + 1'b1;
      end
      ST_FETCH0: w_next = ST_FETCH1;
      ST_FETCH1: w_next = ST_FETCH2;
      ST_FETCH2: w_next = ST_T3;
      ST_HALT:   w_next = ST_HALT;
      default: begin
        if (r_state == last_step(w_op)) begin
          w_next = w_halt_op ? ST_HALT : w_boundary;
        end else begin
          case (r_state)
            ST_T3:   w_next = ST_T4;
            ST_T4:   w_next = ST_T5;
            ST_T5:   w_next = ST_T6;
            ST_T6:   w_next = ST_T7;
            default: w_next = w_boundary;
          endcase
        end
      end
    endcase
  end

  control_step_decoder u_dec (
    .i_state  (r_state),
    .i_opcode (w_op),
    .i_con    (CON_in),
    .o_ctrl   (w_ctrl)
  );

  assign PC_in      = w_ctrl.pc_in;
  assign IR_in      = w_ctrl.ir_in;
  assign Y_in       = w_ctrl.y_in;
  assign Z_in       = w_ctrl.z_in;
  assign HI_in      = w_ctrl.hi_in;
  assign LO_in      = w_ctrl.lo_in;
  assign MAR_in     = w_ctrl.mar_in;
  assign MDR_in     = w_ctrl.mdr_in;
  assign OutPort_in = w_ctrl.outport_in;
  assign IncPC      = w_ctrl.inc_pc;
  assign PC_out     = w_ctrl.pc_out;
  assign Zhigh_out  = w_ctrl.zhigh_out;
  assign Zlow_out   = w_ctrl.zlow_out;
  assign HI_out     = w_ctrl.hi_out;
  assign LO_out     = w_ctrl.lo_out;
  assign MDR_out    = w_ctrl.mdr_out;
  assign InPort_out = w_ctrl.inport_out;
  assign C_out      = w_ctrl.c_out;
  assign Read       = w_ctrl.read;
  assign Write      = w_ctrl.write;
  assign Gra        = w_ctrl.gra;
  assign Grb        = w_ctrl.grb;
  assign Grc        = w_ctrl.grc;
  assign Rin        = w_ctrl.rin;
  assign Rout       = w_ctrl.rout;
  assign BAout      = w_ctrl.baout;
  assign CON_en     = w_ctrl.con_en;
  assign R15_in     = w_ctrl.r15_in;
  assign alu_instruction_bits = w_ctrl.alu;
  assign Run        = (r_state != ST_RESET) && (r_state != ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model (mode + step index into
// each opcode's strobe list) checked every negedge, plus literal step checks.
module tb_control_unit;

  localparam int RC = 1;

  logic clk = 1'b0, clr = 1'b0, CON_in = 1'b0, Stop = 1'b0;
  logic [31:0] IR = 32'h0880_0075;
  logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_en, R15_in, Run;
  logic [4:0] alu_instruction_bits;

  control_unit #(.RESET_CYCLES(RC), .HALT_ON_UNKNOWN(0)) dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_in(CON_in), .Stop(Stop),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC),
    .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
    .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .CON_en(CON_en), .R15_in(R15_in),
    .alu_instruction_bits(alu_instruction_bits), .Run(Run)
  );

  always #5 clk = ~clk;

  // Strobe bit positions in the packed comparison word
  localparam logic [27:0] M_PC_in = 28'h1 << 0,  M_IR_in = 28'h1 << 1,  M_Y_in = 28'h1 << 2;
  localparam logic [27:0] M_Z_in = 28'h1 << 3,   M_HI_in = 28'h1 << 4,  M_LO_in = 28'h1 << 5;
  localparam logic [27:0] M_MAR_in = 28'h1 << 6, M_MDR_in = 28'h1 << 7, M_OutP_in = 28'h1 << 8;
  localparam logic [27:0] M_IncPC = 28'h1 << 9,  M_PC_out = 28'h1 << 10, M_Zhi = 28'h1 << 11;
  localparam logic [27:0] M_Zlo = 28'h1 << 12,   M_HI_out = 28'h1 << 13, M_LO_out = 28'h1 << 14;
  localparam logic [27:0] M_MDR_out = 28'h1 << 15, M_InP_out = 28'h1 << 16, M_C_out = 28'h1 << 17;
  localparam logic [27:0] M_Read = 28'h1 << 18,  M_Write = 28'h1 << 19, M_Gra = 28'h1 << 20;
  localparam logic [27:0] M_Grb = 28'h1 << 21,   M_Grc = 28'h1 << 22,   M_Rin = 28'h1 << 23;
  localparam logic [27:0] M_Rout = 28'h1 << 24,  M_BAout = 28'h1 << 25, M_CON_en = 28'h1 << 26;
  localparam logic [27:0] M_R15 = 28'h1 << 27;

  logic [27:0] w_sig;
  logic [33:0] dut_all;
  assign w_sig = {R15_in, CON_en, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, C_out,
                  InPort_out, MDR_out, LO_out, HI_out, Zlow_out, Zhigh_out, PC_out, IncPC,
                  OutPort_in, MDR_in, MAR_in, LO_in, HI_in, Z_in, Y_in, IR_in, PC_in};
  assign dut_all = {Run, alu_instruction_bits, w_sig};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [33:0] W(input logic [4:0] a, input logic [27:0] m);
    return {1'b1, a, m};
  endfunction

  // ---------------- instruction-level model ----------------
  function automatic int n_exec(input logic [4:0] op);
    if (op <= 5'd2)  return (op == 5'd1) ? 3 : 5;
    if (op <= 5'd14) return 3;
    if (op <= 5'd16) return 4;
    if (op <= 5'd18) return 2;
    if (op == 5'd19) return 4;
    if (op == 5'd21) return 2;
    return 1;
  endfunction

  // {alu, strobes} of execute step k (0 = T3) for an opcode
  function automatic logic [32:0] exec_step(input logic [4:0] op, input int k, input logic con);
    logic [4:0] ia;
    ia = (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : 5'd3;
    if (op <= 5'd2) begin
      case (k)
        0: return {5'd0, M_Grb | M_BAout | M_Y_in};
        1: return {5'd3, M_C_out | M_Z_in};
        2: return {5'd0, (op == 5'd1) ? (M_Zlo | M_Gra | M_Rin) : (M_Zlo | M_MAR_in)};
        3: return {5'd0, (op == 5'd2) ? (M_Gra | M_Rout | M_MDR_in) : (M_Read | M_MDR_in)};
        default: return {5'd0, (op == 5'd2) ? M_Write : (M_MDR_out | M_Gra | M_Rin)};
      endcase
    end else if (op <= 5'd14) begin
      case (k)
        0: return {5'd0, M_Grb | M_Rout | M_Y_in};
        1: return (op <= 5'd11) ? {op, M_Grc | M_Rout | M_Z_in} : {ia, M_C_out | M_Z_in};
        default: return {5'd0, M_Zlo | M_Gra | M_Rin};
      endcase
    end else if (op <= 5'd16) begin
      case (k)
        0: return {5'd0, M_Gra | M_Rout | M_Y_in};
        1: return {op, M_Grb | M_Rout | M_Z_in};
        2: return {5'd0, M_Zlo | M_LO_in};
        default: return {5'd0, M_Zhi | M_HI_in};
      endcase
    end else if (op <= 5'd18) begin
      return (k == 0) ? {op, M_Grb | M_Rout | M_Z_in} : {5'd0, M_Zlo | M_Gra | M_Rin};
    end
    case (op)
      5'd19: case (k)
               0: return {5'd0, M_Gra | M_Rout | M_CON_en};
               1: return {5'd0, M_PC_out | M_Y_in};
               2: return {5'd3, M_C_out | M_Z_in};
               default: return {5'd0, M_Zlo | (con ? M_PC_in : 28'h0)};
             endcase
      5'd20: return {5'd0, M_Gra | M_Rout | M_PC_in};
      5'd21: return (k == 0) ? {5'd0, M_PC_out | M_R15} : {5'd0, M_Gra | M_Rout | M_PC_in};
      5'd22: return {5'd0, M_InP_out | M_Gra | M_Rin};
      5'd23: return {5'd0, M_Gra | M_Rout | M_OutP_in};
      5'd24: return {5'd0, M_HI_out | M_Gra | M_Rin};
      5'd25: return {5'd0, M_LO_out | M_Gra | M_Rin};
      default: return 33'h0;
    endcase
  endfunction

  // mode: 0 reset idle, 1 running (m_idx = step within instruction), 2 halted
  int m_mode = 0, m_rcnt = 0, m_idx = 0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_mode <= 0; m_rcnt <= 0; m_idx <= 0;
    end else if (m_mode == 0) begin
      if (m_rcnt == RC - 1) begin m_mode <= Stop ? 2 : 1; m_idx <= 0; end
      else m_rcnt <= m_rcnt + 1;
    end else if (m_mode == 1) begin
      if (m_idx == 2 + n_exec(IR[31:27])) begin
        if (IR[31:27] == 5'd27) m_mode <= 2;
        else begin m_mode <= Stop ? 2 : 1; m_idx <= 0; end
      end else m_idx <= m_idx + 1;
    end
  end

  function automatic logic [33:0] model_expect();
    if (m_mode != 1) return 34'h0;
    case (m_idx)
      0: return W(5'd0, M_PC_out | M_MAR_in | M_IncPC | M_Z_in);
      1: return W(5'd0, M_Zlo | M_PC_in | M_Read | M_MDR_in);
      2: return W(5'd0, M_MDR_out | M_IR_in);
      default: return {1'b1, exec_step(IR[31:27], m_idx - 3, CON_in)};
    endcase
  endfunction

  always @(negedge clk) chk("cycle", dut_all, model_expect());

  // ---------------- directed stimulus ----------------
  logic [33:0] snap [0:15];
  int len;

  function automatic logic is_f0();
    return PC_out && MAR_in;
  endfunction

  task automatic wait_f0(output int k);
    k = 0;
    repeat (40) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (is_f0()) return;
    end
    k = -1;
  endtask

  // Starts on the FETCH0 negedge of the instruction; returns on the next FETCH0.
  task automatic run_instr(input logic [31:0] ir, input logic con, output int n);
    snap[0] = dut_all;
    #1 IR = ir; CON_in = con;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (is_f0()) begin n = k; return; end
      if (k < 16) snap[k] = dut_all;
    end
    n = -1;
  endtask

  initial begin
    int k, cnt;
    #1 clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", dut_all, 34'h0);
    @(posedge clk); #2 clr = 1'b0;
    wait_f0(k);
    chk("reset_to_fetch0", 34'(k), 34'(RC));

    run_instr(32'h0880_0075, 1'b0, len);             // ldi
    chk("ldi_len", 34'(len), 34'd6);
    chk("ldi_T3", snap[3], W(5'd0, M_Grb | M_BAout | M_Y_in));
    chk("ldi_T4", snap[4], W(5'd3, M_C_out | M_Z_in));
    chk("ldi_T5", snap[5], W(5'd0, M_Zlo | M_Gra | M_Rin));

    run_instr(32'h0080_0010, 1'b0, len);             // ld
    chk("ld_len", 34'(len), 34'd8);
    chk("ld_T5", snap[5], W(5'd0, M_Zlo | M_MAR_in));
    chk("ld_T6", snap[6], W(5'd0, M_Read | M_MDR_in));
    chk("ld_T7", snap[7], W(5'd0, M_MDR_out | M_Gra | M_Rin));

    run_instr(32'h1891_8000, 1'b0, len);             // add R1,R2,R3
    chk("add_len", 34'(len), 34'd6);
    chk("add_T4", snap[4], W(5'd3, M_Grc | M_Rout | M_Z_in));
    chk("add_T5", snap[5], W(5'd0, M_Zlo | M_Gra | M_Rin));

    run_instr(32'h9800_0000, 1'b0, len);             // br, not taken
    chk("br0_len", 34'(len), 34'd7);
    chk("br0_T6", snap[6], W(5'd0, M_Zlo));
    run_instr(32'h9800_0000, 1'b1, len);             // br, taken
    chk("br1_T6", snap[6], W(5'd0, M_Zlo | M_PC_in));

    run_instr(32'h1080_0000, 1'b0, len);             // st
    chk("st_len", 34'(len), 34'd8);
    chk("st_T6", snap[6], W(5'd0, M_Gra | M_Rout | M_MDR_in));
    chk("st_T7", snap[7], W(5'd0, M_Write));

    run_instr(32'h8000_0000, 1'b0, len);             // mul
    chk("mul_len", 34'(len), 34'd7);
    chk("mul_T6", snap[6], W(5'd0, M_Zhi | M_HI_in));

    run_instr(32'hA800_0000, 1'b0, len);             // jal
    chk("jal_len", 34'(len), 34'd5);
    chk("jal_T3", snap[3], W(5'd0, M_PC_out | M_R15));

    run_instr(32'h8800_0000, 1'b0, len);             // neg
    chk("neg_T3", snap[3], W(5'd17, M_Grb | M_Rout | M_Z_in));
    run_instr(32'h6800_0000, 1'b0, len);             // andi
    chk("andi_T4", snap[4], W(5'd5, M_C_out | M_Z_in));
    run_instr(32'hE000_0000, 1'b0, len);             // undefined -> nop
    chk("unknown_len", 34'(len), 34'd4);

    // halt instruction
    #1 IR = 32'hD800_0000;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("halt_T3_run", 34'(Run), 34'd1);
    @(posedge clk); @(negedge clk); chk("halt_run", 34'(Run), 34'd0);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (PC_out) cnt++; end
    chk("halt_no_pc_out", 34'(cnt), 34'd0);
    #1 clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
    wait_f0(k);
    chk("halt_recover", 34'(k), 34'(RC));

    // clr mid-ld at T6
    #1 IR = 32'h0080_0010;
    repeat (6) @(posedge clk);
    @(negedge clk); chk("ld_T6_pre_clr", dut_all, W(5'd0, M_Read | M_MDR_in));
    #1 clr = 1'b1;
    #1 chk("clr_async_drop", dut_all, 34'h0);
    @(posedge clk); #2 clr = 1'b0;
    wait_f0(k);
    chk("clr_restart", 34'(k), 34'(RC));

    // Stop at the instruction boundary
    #1 IR = 32'hD000_0000; Stop = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("stop_halt", dut_all, 34'h0);
    repeat (3) @(negedge clk);
    chk("stop_stays", dut_all, 34'h0);
    #1 clr = 1'b1; Stop = 1'b0;
    @(posedge clk); #2 clr = 1'b0;
    wait_f0(k);
    chk("stop_recover", 34'(k), 34'(RC));
    @(posedge clk); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
